// File: rtl/mm_cache_pkg.sv
// rtl/mm_cache_pkg.sv - shared parameters, FSM/op enums and line metadata for mm_cache
package mm_cache_pkg;

    localparam int DEF_INDEX      = 16;
    localparam int DEF_BLOCK_BITS = 512;
    localparam int DEF_OFF_W      = $clog2(DEF_BLOCK_BITS / 8);
    localparam int DEF_IDX_W      = $clog2(DEF_INDEX);
    localparam int DEF_TAG_W      = 32 - DEF_OFF_W - DEF_IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVICT,
        ST_FETCH,
        ST_RESPOND,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        OP_IREAD,
        OP_DREAD,
        OP_WB
    } op_t;

    typedef struct packed {
        logic valid;
        logic dirty;
    } line_meta_t;

    function automatic logic [31:0] align_addr(input logic [31:0] a, input int off_w);
        return a & ~((32'd1 << off_w) - 32'd1);
    endfunction

endpackage

// File: rtl/mm_cache_array.sv
// rtl/mm_cache_array.sv - line storage: valid/dirty metadata, tags and data, one read and one write port
module mm_cache_array
    import mm_cache_pkg::*;
#(
    parameter int INDEX      = DEF_INDEX,
    parameter int BLOCK_BITS = DEF_BLOCK_BITS,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int TAG_W      = DEF_TAG_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic                  rd_valid_o,
    output logic                  rd_dirty_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [BLOCK_BITS-1:0] rd_data_o,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic                  wr_dirty_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [BLOCK_BITS-1:0] wr_data_i
);

    line_meta_t            meta_q [INDEX];
    line_meta_t            meta_d [INDEX];
    logic [TAG_W-1:0]      tag_mem_q [INDEX];
    logic [BLOCK_BITS-1:0] data_mem_q [INDEX];

    always_comb begin
        meta_d = meta_q;
        if (we_i) begin
            meta_d[wr_idx_i] = '{valid: 1'b1, dirty: wr_dirty_i};
        end
    end

    // Only metadata is reset; tag/data contents are meaningless while valid is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < INDEX; i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            meta_q <= meta_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_mem_q[wr_idx_i]  <= wr_tag_i;
            data_mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = meta_q[rd_idx_i].valid;
    assign rd_dirty_o = meta_q[rd_idx_i].dirty;
    assign rd_tag_o   = tag_mem_q[rd_idx_i];
    assign rd_data_o  = data_mem_q[rd_idx_i];

endmodule

// File: rtl/mm_cache.sv
// rtl/mm_cache.sv - direct-mapped write-back cache shared by ICache and DCache, one transaction at a time
module mm_cache
    import mm_cache_pkg::*;
#(
    parameter int INDEX      = DEF_INDEX,
    parameter int BLOCK_BITS = DEF_BLOCK_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           addr_in_icache_i,
    input  logic                  ichache_request_i,
    output logic [BLOCK_BITS-1:0] data_out_icache_request_o,
    output logic [31:0]           addr_out_icache_request_o,
    output logic                  icache_request_valid_o,
    input  logic [31:0]           addr_in_dcache_i,
    input  logic [BLOCK_BITS-1:0] data_in_dcache_i,
    input  logic                  dchache_request_i,
    input  logic                  dcache_evict_i,
    output logic [31:0]           addr_out_dcache_request_o,
    output logic [BLOCK_BITS-1:0] data_out_dcache_request_o,
    output logic                  dcache_request_valid_o,
    output logic                  dcache_evict_o,
    input  logic [BLOCK_BITS-1:0] data_in_request_i,
    input  logic [31:0]           addr_in_request_i,
    input  logic                  request_valid_i,
    output logic [31:0]           addr_out_request_o,
    output logic                  request_o,
    input  logic                  evict_i,
    output logic [BLOCK_BITS-1:0] data_out_evict_o,
    output logic [31:0]           addr_out_evict_o,
    output logic                  evict_o
);

    localparam int OFF_W = $clog2(BLOCK_BITS / 8);
    localparam int IDX_W = $clog2(INDEX);
    localparam int TAG_W = 32 - OFF_W - IDX_W;

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic [31:0]           addr_q, addr_d;
    logic [BLOCK_BITS-1:0] wdata_q, wdata_d;

    logic                  sel_valid;
    op_t                   sel_op;
    logic [31:0]           sel_addr;
    logic [31:0]           cur_addr;
    logic [IDX_W-1:0]      cur_idx;
    logic [TAG_W-1:0]      cur_tag;
    logic                  hit;
    logic                  victim_dirty;

    logic                  rd_valid, rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [BLOCK_BITS-1:0] rd_data;
    logic                  arr_we, arr_wr_dirty;
    logic [BLOCK_BITS-1:0] arr_wr_data;

    always_comb begin
        sel_valid = 1'b1;
        sel_op    = OP_IREAD;
        sel_addr  = addr_in_icache_i;
        if (dcache_evict_i) begin
            sel_op   = OP_WB;
            sel_addr = addr_in_dcache_i;
        end else if (dchache_request_i) begin
            sel_op   = OP_DREAD;
            sel_addr = addr_in_dcache_i;
        end else if (!ichache_request_i) begin
            sel_valid = 1'b0;
        end
    end

    // In IDLE the array is looked up with the incoming address so the hit/miss
    // decision is taken on the accepting edge; afterwards the latched address is used.
    assign cur_addr = (state_q == ST_IDLE) ? align_addr(sel_addr, OFF_W) : addr_q;
    assign cur_idx  = cur_addr[OFF_W +: IDX_W];
    assign cur_tag  = cur_addr[31 -: TAG_W];
    assign hit          = rd_valid && ({rd_tag, cur_idx, {OFF_W{1'b0}}} == cur_addr);
    assign victim_dirty = rd_valid && rd_dirty && (rd_tag != cur_tag);

    mm_cache_array #(
        .INDEX      (INDEX),
        .BLOCK_BITS (BLOCK_BITS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (cur_idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (arr_we),
        .wr_idx_i   (cur_idx),
        .wr_dirty_i (arr_wr_dirty),
        .wr_tag_i   (cur_tag),
        .wr_data_i  (arr_wr_data)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        arr_we       = 1'b0;
        arr_wr_dirty = 1'b0;
        arr_wr_data  = data_in_request_i;

        data_out_icache_request_o = '0;
        addr_out_icache_request_o = '0;
        icache_request_valid_o    = 1'b0;
        addr_out_dcache_request_o = '0;
        data_out_dcache_request_o = '0;
        dcache_request_valid_o    = 1'b0;
        dcache_evict_o            = 1'b0;
        addr_out_request_o        = '0;
        request_o                 = 1'b0;
        data_out_evict_o          = '0;
        addr_out_evict_o          = '0;
        evict_o                   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    op_d    = sel_op;
                    addr_d  = cur_addr;
                    wdata_d = data_in_dcache_i;
                    if (victim_dirty) begin
                        state_d = ST_EVICT;
                    end else if (sel_op == OP_WB || hit) begin
                        state_d = ST_RESPOND;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_EVICT: begin
                evict_o          = 1'b1;
                data_out_evict_o = rd_data;
                addr_out_evict_o = {rd_tag, cur_idx, {OFF_W{1'b0}}};
                if (evict_i) begin
                    state_d = (op_q == OP_WB) ? ST_RESPOND : ST_FETCH;
                end
            end
            ST_FETCH: begin
                request_o          = 1'b1;
                addr_out_request_o = addr_q;
                if (request_valid_i && align_addr(addr_in_request_i, OFF_W) == addr_q) begin
                    arr_we  = 1'b1;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_GAP;
                unique case (op_q)
                    OP_IREAD: begin
                        icache_request_valid_o    = 1'b1;
                        data_out_icache_request_o = rd_data;
                        addr_out_icache_request_o = addr_q;
                    end
                    OP_DREAD: begin
                        dcache_request_valid_o    = 1'b1;
                        data_out_dcache_request_o = rd_data;
                        addr_out_dcache_request_o = addr_q;
                    end
                    default: begin
                        dcache_evict_o = 1'b1;
                        arr_we         = 1'b1;
                        arr_wr_dirty   = 1'b1;
                        arr_wr_data    = wdata_q;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_IREAD;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mm_cache.sv
// tb/tb_mm_cache.sv - directed self-checking bench for mm_cache
module tb_mm_cache;

    localparam int BB = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   addr_in_icache = '0;
    logic          ireq = 1'b0;
    logic [BB-1:0] idata_out;
    logic [31:0]   iaddr_out;
    logic          ivalid;
    logic [31:0]   addr_in_dcache = '0;
    logic [BB-1:0] data_in_dcache = '0;
    logic          dreq = 1'b0;
    logic          dwb = 1'b0;
    logic [31:0]   daddr_out;
    logic [BB-1:0] ddata_out;
    logic          dvalid;
    logic          dwb_ack;
    logic [BB-1:0] fill_data = '0;
    logic [31:0]   fill_addr = '0;
    logic          fill_valid = 1'b0;
    logic [31:0]   req_addr;
    logic          req;
    logic          evict_ack = 1'b0;
    logic [BB-1:0] ev_data;
    logic [31:0]   ev_addr;
    logic          ev;

    int checks = 0;
    int failures = 0;

    logic [BB-1:0] d0, d1, d2, junk;

    always #5 clk = ~clk;

    mm_cache dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .addr_in_icache_i          (addr_in_icache),
        .ichache_request_i         (ireq),
        .data_out_icache_request_o (idata_out),
        .addr_out_icache_request_o (iaddr_out),
        .icache_request_valid_o    (ivalid),
        .addr_in_dcache_i          (addr_in_dcache),
        .data_in_dcache_i          (data_in_dcache),
        .dchache_request_i         (dreq),
        .dcache_evict_i            (dwb),
        .addr_out_dcache_request_o (daddr_out),
        .data_out_dcache_request_o (ddata_out),
        .dcache_request_valid_o    (dvalid),
        .dcache_evict_o            (dwb_ack),
        .data_in_request_i         (fill_data),
        .addr_in_request_i         (fill_addr),
        .request_valid_i           (fill_valid),
        .addr_out_request_o        (req_addr),
        .request_o                 (req),
        .evict_i                   (evict_ack),
        .data_out_evict_o          (ev_data),
        .addr_out_evict_o          (ev_addr),
        .evict_o                   (ev)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"}, {511'd0, req}, '0);
        chk({tag, "_ev"}, {511'd0, ev}, '0);
        chk({tag, "_ivalid"}, {511'd0, ivalid}, '0);
        chk({tag, "_dvalid"}, {511'd0, dvalid}, '0);
        chk({tag, "_dwback"}, {511'd0, dwb_ack}, '0);
        chk({tag, "_idata"}, idata_out, '0);
        chk({tag, "_evaddr"}, {480'd0, ev_addr}, '0);
    endtask

    initial begin
        d0   = {16{32'hD0D0_0001}};
        d1   = {16{32'hD1D1_0002}};
        d2   = {16{32'hD2D2_0003}};
        junk = {16{32'hBAD0_BAD0}};

        // reset
        step();
        step();
        rst = 1'b0;
        chk_idle_outputs("reset");

        // cold ICache read, first a mismatching fill then the right one
        addr_in_icache = 32'h0000_1040;
        ireq = 1'b1;
        step();
        chk("cold_req", {511'd0, req}, 1);
        chk("cold_req_addr", {480'd0, req_addr}, 32'h0000_1040);
        chk("cold_no_ev", {511'd0, ev}, 0);
        fill_valid = 1'b1;
        fill_addr  = 32'h0000_3040;
        fill_data  = junk;
        step();
        chk("badfill_req_held", {511'd0, req}, 1);
        chk("badfill_no_valid", {511'd0, ivalid}, 0);
        fill_addr = 32'h0000_1044;
        fill_data = d0;
        step();
        fill_valid = 1'b0;
        chk("cold_ivalid", {511'd0, ivalid}, 1);
        chk("cold_idata", idata_out, d0);
        chk("cold_iaddr", {480'd0, iaddr_out}, 32'h0000_1040);
        chk("cold_req_drop", {511'd0, req}, 0);
        ireq = 1'b0;
        step();
        chk("gap_ivalid", {511'd0, ivalid}, 0);
        chk("gap_idata", idata_out, '0);
        step();

        // ICache hit on the same line
        addr_in_icache = 32'h0000_1060;
        ireq = 1'b1;
        step();
        chk("hit_ivalid", {511'd0, ivalid}, 1);
        chk("hit_idata", idata_out, d0);
        chk("hit_iaddr", {480'd0, iaddr_out}, 32'h0000_1040);
        chk("hit_no_req", {511'd0, req}, 0);
        ireq = 1'b0;
        step();
        step();

        // DCache write-back then read back without a fetch
        addr_in_dcache = 32'h0000_2000;
        data_in_dcache = d1;
        dwb = 1'b1;
        step();
        chk("wb_ack", {511'd0, dwb_ack}, 1);
        chk("wb_no_req", {511'd0, req}, 0);
        dwb = 1'b0;
        data_in_dcache = junk;
        step();
        chk("wb_ack_once", {511'd0, dwb_ack}, 0);
        step();
        dreq = 1'b1;
        step();
        chk("drd_valid", {511'd0, dvalid}, 1);
        chk("drd_data", ddata_out, d1);
        chk("drd_addr", {480'd0, daddr_out}, 32'h0000_2000);
        chk("drd_no_req", {511'd0, req}, 0);
        dreq = 1'b0;
        step();
        step();

        // conflict miss with dirty victim
        addr_in_icache = 32'h0000_2400;
        ireq = 1'b1;
        step();
        chk("ev_req", {511'd0, ev}, 1);
        chk("ev_addr", {480'd0, ev_addr}, 32'h0000_2000);
        chk("ev_data", ev_data, d1);
        chk("ev_no_fill_req", {511'd0, req}, 0);
        addr_in_icache = 32'h0000_1040;
        step();
        chk("ev_held", {511'd0, ev}, 1);
        evict_ack = 1'b1;
        step();
        evict_ack = 1'b0;
        chk("ev_done", {511'd0, ev}, 0);
        chk("ev_then_req", {511'd0, req}, 1);
        chk("ev_then_req_addr", {480'd0, req_addr}, 32'h0000_2400);
        fill_valid = 1'b1;
        fill_addr  = 32'h0000_2400;
        fill_data  = d2;
        step();
        fill_valid = 1'b0;
        chk("ev_fill_ivalid", {511'd0, ivalid}, 1);
        chk("ev_fill_idata", idata_out, d2);
        chk("ev_fill_iaddr", {480'd0, iaddr_out}, 32'h0000_2400);
        ireq = 1'b0;
        step();
        step();

        // simultaneous DCache and ICache reads: DCache first
        addr_in_icache = 32'h0000_1040;
        addr_in_dcache = 32'h0000_2400;
        ireq = 1'b1;
        dreq = 1'b1;
        step();
        chk("arb_dvalid", {511'd0, dvalid}, 1);
        chk("arb_ddata", ddata_out, d2);
        chk("arb_ivalid_low", {511'd0, ivalid}, 0);
        dreq = 1'b0;
        step();
        chk("arb_gap_ivalid", {511'd0, ivalid}, 0);
        step();
        step();
        chk("arb_ivalid", {511'd0, ivalid}, 1);
        chk("arb_idata", idata_out, d0);
        ireq = 1'b0;
        step();
        step();

        // reset during FETCH
        addr_in_icache = 32'h0000_5040;
        ireq = 1'b1;
        step();
        chk("rstf_req", {511'd0, req}, 1);
        rst = 1'b1;
        ireq = 1'b0;
        fill_valid = 1'b1;
        fill_addr = 32'h0000_5040;
        fill_data = junk;
        step();
        rst = 1'b0;
        fill_valid = 1'b0;
        chk_idle_outputs("rstf");
        step();
        chk("rstf_no_resp", {511'd0, ivalid}, 0);
        addr_in_icache = 32'h0000_1040;
        ireq = 1'b1;
        step();
        chk("post_rst_miss", {511'd0, req}, 1);
        chk("post_rst_addr", {480'd0, req_addr}, 32'h0000_1040);
        chk("post_rst_ivalid", {511'd0, ivalid}, 0);
        ireq = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_cache.md
MM_CACHE -- requirements
Module: mm_cache

Interface
REQ-001 SHALL take parameters: INDEX, default 16, number of cache lines (power of 2); BLOCK_BITS, default 512, line width in bits (power of 2, >=8).
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk_i  in  1  single clock, all logic on rising edge
 rst_i  in  1  synchronous, active-high reset
 addr_in_icache_i  in  32  ICache block read address
 ichache_request_i  in  1  ICache read request, level, held until valid
 data_out_icache_request_o  out  BLOCK_BITS  block returned to ICache
 addr_out_icache_request_o  out  32  block-aligned address of returned block
 icache_request_valid_o  out  1  one-cycle response strobe to ICache
 addr_in_dcache_i  in  32  DCache read or write-back address
 data_in_dcache_i  in  BLOCK_BITS  DCache write-back block
 dchache_request_i  in  1  DCache read request, level, held until valid
 dcache_evict_i  in  1  DCache write-back request, level, held until ack
 addr_out_dcache_request_o  out  32  block-aligned address of returned block
 data_out_dcache_request_o  out  BLOCK_BITS  block returned to DCache
 dcache_request_valid_o  out  1  one-cycle read response strobe to DCache
 dcache_evict_o  out  1  one-cycle write-back ack to DCache
 data_in_request_i  in  BLOCK_BITS  fill block from higher level
 addr_in_request_i  in  32  address of fill block
 request_valid_i  in  1  fill block valid
 addr_out_request_o  out  32  block-aligned fill address requested
 request_o  out  1  fill request, held until matching fill
 evict_i  in  1  higher-level ack of write-back
 data_out_evict_o  out  BLOCK_BITS  victim block
 addr_out_evict_o  out  32  victim block address
 evict_o  out  1  write-back request, held until evict_i

Function
REQ-003 SHALL be direct-mapped, write-back, write-allocate; per line: valid, dirty, tag, data.
REQ-004 SHALL split address: offset = log2(BLOCK_BITS/8) LSBs (6), index = next log2(INDEX) bits (4), tag = remaining MSBs (22); all output addresses SHALL have offset bits zero.
REQ-005 SHALL serve one transaction at a time; FSM states IDLE, EVICT, FETCH, RESPOND, GAP.
REQ-006 IDLE arbitration priority: dcache_evict_i > dchache_request_i > ichache_request_i; selected address/data latched on the accepting edge.
REQ-007 Read hit: RESPOND next cycle; matching valid strobe high exactly one cycle with line data and aligned address; then GAP one cycle (requests ignored) then IDLE.
REQ-008 Read miss, victim clean or invalid: FETCH; request_o=1, addr_out_request_o=aligned address, held until request_valid_i=1 with addr_in_request_i aligned-equal; mismatching fills ignored; on match line written valid, clean, then RESPOND.
REQ-009 Miss with valid dirty victim: EVICT first; evict_o=1 with victim data and {tag,index,0} address held until evict_i=1; then FETCH (read) or write (write-back).
REQ-010 DCache write-back: overwrite full line with data_in_dcache_i, set valid and dirty, tag updated, no fetch; dcache_evict_o pulses one cycle; then GAP.
REQ-011 request_o and evict_o SHALL never be high simultaneously; all response outputs zero when their strobe is low.
REQ-012 Request inputs changing while not IDLE SHALL not affect the transaction in progress.

Reset
REQ-013 On rst_i=1 at a rising edge: state IDLE, all valid and dirty bits 0, all outputs 0; data/tag arrays need not be cleared.
REQ-014 Reset mid-transaction SHALL abandon it; no fill or write-back completes afterwards.

Structure
REQ-015 Package mm_cache_pkg SHALL hold default parameters, derived offset/index/tag widths, FSM state enum and line struct.
REQ-016 One sub-module mm_cache_array SHALL hold valid/dirty/tag/data storage with one read and one write port; arbitration and FSM stay in mm_cache.

Verification
REQ-017 Cold ICache read 0x0000_1040 -> request_o with 0x0000_1040, no evict_o; fill D0 -> icache_request_valid_o one cycle, data D0, addr 0x0000_1040.
REQ-018 Repeat ICache read 0x0000_1060 -> hit, valid one cycle after acceptance, data D0, addr 0x0000_1040, request_o stays 0.
REQ-019 DCache write-back 0x0000_2000 data D1 -> dcache_evict_o one cycle, no request_o; DCache read 0x0000_2000 -> D1 without fetch.
REQ-020 ICache read 0x0000_2400 (same index, new tag) -> evict_o addr 0x0000_2000 data D1 until evict_i, then request_o 0x0000_2400.
REQ-021 ichache_request_i and dchache_request_i asserted same cycle -> DCache served first, ICache next; mismatched-address fill ignored.
REQ-022 rst_i during FETCH -> all outputs 0 next cycle; re-reading 0x0000_1040 misses.
